multicycle_control: RTL

Multi-cycle control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It also handles a ready-handshake memory with an optional timeout. It sits between the instruction register (which supplies `OpCode`) and the shared-memory datapath, and drives every mux select and write enable once per cycle.

---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Multi-cycle control unit for the shared-memory MIPS datapath. Sequences
// each instruction through FETCH, DECODE, EXEC, MEM and WB, waits on a
// ready-handshake memory with an optional timeout, and drives every mux
// select and write enable of the datapath.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC; load IR and PC+4 when mem_ready
// DECODE | capture OpCode into r_op; illegal opcodes go to ERR
// EXEC   | ALU operation; beq/j complete here
// MEM    | data access for lw/sw, held until mem_ready
// WB     | register file write (ALU result or loaded data)
// ERR    | illegal opcode or memory timeout; only rst leaves it
//
// Parameters:
//   MEM_TIMEOUT : cycles to wait for mem_ready in FETCH/MEM (0 = wait forever)
//   EN_BRANCH   : 1 = beq and j supported, 0 = both decode as illegal
// Ports:
//   clk, rst (sync, active-high), OpCode[5:0], mem_ready  : inputs
//   Reg_dst, Reg_w, ALU_src, ALU_op[1:0], Mem_r, Mem_w,
//   Mem_to_reg, IorD, IR_w, PC_w, PC_w_cond, PC_src[1:0]  : datapath control
//   instr_done, err, state[2:0]                           : status / debug

module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter bit EN_BRANCH   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OpCode,
   input  logic       mem_ready,
   output logic       Reg_dst,
   output logic       Reg_w,
   output logic       ALU_src,
   output logic [1:0] ALU_op,
   output logic       Mem_r,
   output logic       Mem_w,
   output logic       Mem_to_reg,
   output logic       IorD,
   output logic       IR_w,
   output logic       PC_w,
   output logic       PC_w_cond,
   output logic [1:0] PC_src,
   output logic       instr_done,
   output logic       err,
   output logic [2:0] state
);

   localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd7
   } state_t;

   state_t        r_state;
   logic [5:0]    r_op;
   logic [CW-1:0] r_cnt;
   logic          r_err;

   logic w_legal;
   logic w_expired;
   logic w_lw;
   logic w_sw;

   always_comb begin
      w_legal = 1'b0;
      case (OpCode)
         OP_R, OP_ADDIU, OP_ORI, OP_LW, OP_SW: w_legal = 1'b1;
         OP_BEQ, OP_J:                         w_legal = EN_BRANCH;
         default:                              w_legal = 1'b0;
      endcase
   end

   // A limit of zero means the memory may stall indefinitely.
   assign w_expired = (MEM_TIMEOUT != 0) && (r_cnt == LIMIT);
   assign w_lw      = (r_op == OP_LW);
   assign w_sw      = (r_op == OP_SW);

   // The wait counter is held at zero outside the two wait states, so it is
   // always zero on entry to FETCH or MEM. mem_ready beats an expiring count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_op    <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_cnt <= '0;
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_state <= S_DECODE;
               end else if (w_expired) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DECODE: begin
               r_op <= OpCode;
               if (w_legal) begin
                  r_state <= S_EXEC;
               end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end
            end
            S_EXEC: begin
               case (r_op)
                  OP_BEQ, OP_J: r_state <= S_FETCH;
                  OP_LW, OP_SW: r_state <= S_MEM;
                  default:      r_state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  r_state <= w_lw ? S_WB : S_FETCH;
               end else if (w_expired) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_WB: begin
               r_state <= S_FETCH;
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_ERR;
               r_err   <= 1'b1;
            end
         endcase
      end
   end

   // Control outputs are decoded from state and the captured opcode; rst
   // forces everything low so no enable fires while the block is held.
   always_comb begin
      Reg_dst    = 1'b0;
      Reg_w      = 1'b0;
      ALU_src    = 1'b0;
      ALU_op     = 2'b00;
      Mem_r      = 1'b0;
      Mem_w      = 1'b0;
      Mem_to_reg = 1'b0;
      IorD       = 1'b0;
      IR_w       = 1'b0;
      PC_w       = 1'b0;
      PC_w_cond  = 1'b0;
      PC_src     = 2'b00;
      instr_done = 1'b0;
      err        = 1'b0;
      state      = 3'd0;
      if (!rst) begin
         state = r_state;
         err   = r_err;
         case (r_state)
            S_FETCH: begin
               Mem_r = 1'b1;
               if (mem_ready) begin
                  IR_w = 1'b1;
                  PC_w = 1'b1;
               end
            end
            S_EXEC: begin
               case (r_op)
                  OP_R: begin
                     Reg_dst = 1'b1;
                     ALU_op  = 2'b10;
                  end
                  OP_ADDIU, OP_LW, OP_SW: begin
                     ALU_src = 1'b1;
                  end
                  OP_ORI: begin
                     ALU_src = 1'b1;
                     ALU_op  = 2'b11;
                  end
                  OP_BEQ: begin
                     ALU_op     = 2'b01;
                     PC_w_cond  = 1'b1;
                     PC_src     = 2'b01;
                     instr_done = 1'b1;
                  end
                  OP_J: begin
                     PC_w       = 1'b1;
                     PC_src     = 2'b10;
                     instr_done = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               IorD       = 1'b1;
               ALU_src    = 1'b1;
               Mem_r      = w_lw;
               Mem_w      = w_sw;
               instr_done = w_sw & mem_ready;
            end
            S_WB: begin
               Reg_w      = 1'b1;
               instr_done = 1'b1;
               // Keep the ALU inputs as in EXEC so the written result is stable.
               case (r_op)
                  OP_R: begin
                     Reg_dst = 1'b1;
                     ALU_op  = 2'b10;
                  end
                  OP_ADDIU: ALU_src = 1'b1;
                  OP_ORI: begin
                     ALU_src = 1'b1;
                     ALU_op  = 2'b11;
                  end
                  OP_LW:    Mem_to_reg = 1'b1;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
